// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: multi-cycle control-flow sequencer that owns the
// architectural PC. It fetches through a request/ready handshake, decodes the
// opcode into a branch ALU mode, captures the ALU's next PC and retires.
// Traps (illegal opcode, misaligned target, fetch timeout) halt it until reset.
//
// Optional build macro: BRANCH_PC_SEQUENCER_STATS_EN adds retiredCount and
// takenCount.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   fetchRequest/fetchAddress fetch request and address (current PC)
//   fetchReady/instruction    fetch response
//   instructionOut            latched instruction under execution
//   pcOfInstruction           PC of the latched instruction
//   branchALUMode             mode driven to the branch ALU
//   programCounterInput       next PC from the branch ALU
//   stall                     datapath busy, hold EXECUTE
//   commitEnable              one-cycle retire pulse (combinational)
//   halted, trapCause         sticky halt flag and first trap cause
//   retiredCount, takenCount  retire / taken counters (stats build only)

typedef enum logic [1:0] {
  INCREMENT = 2'd0,
  JAL       = 2'd1,
  JALR      = 2'd2,
  BRANCH    = 2'd3
} BranchALUMode_t;

module branch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           reset,
  output logic           fetchRequest,
  output logic [31:0]    fetchAddress,
  input  logic           fetchReady,
  input  logic [31:0]    instruction,
  output logic [31:0]    instructionOut,
  output logic [31:0]    pcOfInstruction,
  output BranchALUMode_t branchALUMode,
  input  logic [31:0]    programCounterInput,
  input  logic           stall,
  output logic           commitEnable,
  output logic           halted,
  output logic [1:0]     trapCause
`ifdef BRANCH_PC_SEQUENCER_STATS_EN
  ,
  output logic [31:0]    retiredCount,
  output logic [31:0]    takenCount
`endif
);

  localparam int unsigned CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (FETCH_TIMEOUT == 0) ? '0 : CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] TRAP_NONE      = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL   = 2'b01;
  localparam logic [1:0] TRAP_MISALIGN  = 2'b10;
  localparam logic [1:0] TRAP_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic [1:0]       trap_q, trap_d;

  BranchALUMode_t   dec_mode;
  logic             dec_illegal;

  // Opcode decode of the latched instruction
  always_comb begin
    dec_mode    = INCREMENT;
    dec_illegal = 1'b0;
    if (instr_q[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (instr_q[6:0])
        7'b1101111: dec_mode = JAL;
        7'b1100111: dec_mode = JALR;
        7'b1100011: dec_mode = BRANCH;
        default:    dec_mode = INCREMENT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      trap_q   <= TRAP_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    count_d       = count_q;
    halted_d      = halted_q;
    trap_d        = trap_q;
    fetchRequest  = 1'b0;
    branchALUMode = INCREMENT;
    commitEnable  = 1'b0;

    case (state_q)
      S_FETCH: begin
        fetchRequest = 1'b1;
        if (fetchReady) begin
          // A response in the timeout cycle still wins.
          instr_d = instruction;
          count_d = '0;
          state_d = S_EXECUTE;
        end else if (FETCH_TIMEOUT != 0) begin
          if (count_q == CNT_LAST) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            trap_d   = TRAP_TIMEOUT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      S_EXECUTE: begin
        branchALUMode = dec_mode;
        // Illegal opcode halts even while the datapath stalls.
        if (dec_illegal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          trap_d   = TRAP_ILLEGAL;
        end else if (!stall) begin
          if (programCounterInput[1:0] != 2'b00) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            trap_d   = TRAP_MISALIGN;
          end else begin
            commitEnable = 1'b1;
            pc_d         = programCounterInput;
            state_d      = S_FETCH;
          end
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign fetchAddress    = pc_q;
  assign pcOfInstruction = pc_q;
  assign instructionOut  = instr_q;
  assign halted          = halted_q;
  assign trapCause       = trap_q;

`ifdef BRANCH_PC_SEQUENCER_STATS_EN
  logic [31:0] retired_q;
  logic [31:0] taken_q;

  // Retire and taken-branch counters, wrapping at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else if (commitEnable) begin
      retired_q <= retired_q + 32'd1;
      if (programCounterInput != (pc_q + 32'd4)) begin
        taken_q <= taken_q + 32'd1;
      end
    end
  end

  assign retiredCount = retired_q;
  assign takenCount   = taken_q;
`endif

endmodule
